// File: rtl/cache_pkg.sv
// Shared types for the cache controller / refill engine slice: the request
// packet layout, the refill engine state encoding and way normalisation.
package cache_pkg;

  localparam int PKT_ADDR_WIDTH = 32;
  localparam int PKT_NUM_WAYS   = 4;
  localparam int MAX_WAYS       = 32;

  typedef struct packed {
    logic                      flush;
    logic [PKT_NUM_WAYS-1:0]   way;
    logic [PKT_ADDR_WIDTH-1:0] addr;
  } ds_pkt;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL_REQ,
    S_FILL_DATA,
    S_WB_REQ,
    S_WB_RD,
    S_WB_DATA,
    S_ACK
  } state_e;

  // Lowest set bit as a one-hot; an all-zero field maps to way 0 because the
  // upstream LRU does not yet produce a selection.
  function automatic logic [MAX_WAYS-1:0] onehot_lowest(input logic [MAX_WAYS-1:0] way);
    logic [MAX_WAYS-1:0] r;
    r    = '0;
    r[0] = 1'b1;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (way[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_refill_engine.sv
// Cache refill engine: pops one {flush, way, addr} request at a time and runs
// either a line fill (memory burst read -> data array) or a line writeback
// (data array -> memory burst write), then pulses ack_o.
module cache_refill_engine
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WAYS   = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           qvld_i,
  output logic                           qrdy_o,
  input  logic [NUM_WAYS+ADDR_WIDTH:0]   qdat_i,
  output logic                           ack_o,
  output logic                           mreq_o,
  input  logic                           mgnt_i,
  output logic                           mwe_o,
  output logic [ADDR_WIDTH-1:0]          maddr_o,
  input  logic                           mrvld_i,
  input  logic [DATA_WIDTH-1:0]          mrdat_i,
  output logic                           mwvld_o,
  input  logic                           mwrdy_i,
  output logic [DATA_WIDTH-1:0]          mwdat_o,
  output logic                           are_o,
  output logic                           awe_o,
  output logic [NUM_WAYS-1:0]            away_o,
  output logic [ADDR_WIDTH-1:0]          aaddr_o,
  output logic [DATA_WIDTH-1:0]          awdat_o,
  input  logic [DATA_WIDTH-1:0]          ardat_i
);

  localparam int CW        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int BSH       = $clog2(DATA_WIDTH / 8);
  localparam int OFFS      = $clog2(LINE_WORDS * (DATA_WIDTH / 8));
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << OFFS) - ADDR_WIDTH'(1));

  state_e                  state, nxt;
  logic [CW-1:0]           cnt_q;
  logic                    first_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [NUM_WAYS-1:0]     way_q;
  logic [DATA_WIDTH-1:0]   hold_q;
  logic                    cnt_inc;
  logic                    beat;
  logic                    pkt_flush;
  logic [MAX_WAYS-1:0]     way_oh;
  logic [ADDR_WIDTH-1:0]   word_addr;

  assign pkt_flush = qdat_i[NUM_WAYS+ADDR_WIDTH];
  assign way_oh    = onehot_lowest(MAX_WAYS'(qdat_i[ADDR_WIDTH +: NUM_WAYS]));
  assign beat      = qvld_i && qrdy_o;
  assign word_addr = base_q + (ADDR_WIDTH'(cnt_q) << BSH);

  // Control state: FSM state, word counter and first-cycle-of-WB_DATA flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state   <= nxt;
      first_q <= (state == S_WB_RD);
      if (beat) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Datapath registers; every output using them is gated by state, so they
  // need no reset.
  always_ff @(posedge clk) begin
    if (beat) begin
      base_q <= qdat_i[ADDR_WIDTH-1:0] & LINE_MASK;
      way_q  <= way_oh[NUM_WAYS-1:0];
    end
    if (state == S_WB_DATA && first_q) begin
      hold_q <= ardat_i;
    end
  end

  // Next-state and output decode. In the first WB_DATA cycle the array data
  // is passed straight through; afterwards the held copy keeps mwdat_o stable.
  always_comb begin
    nxt     = state;
    cnt_inc = 1'b0;
    qrdy_o  = 1'b0;
    ack_o   = 1'b0;
    mreq_o  = 1'b0;
    mwe_o   = 1'b0;
    maddr_o = '0;
    mwvld_o = 1'b0;
    mwdat_o = '0;
    are_o   = 1'b0;
    awe_o   = 1'b0;
    away_o  = '0;
    aaddr_o = '0;
    awdat_o = '0;
    case (state)
      S_IDLE: begin
        qrdy_o = 1'b1;
        if (qvld_i) nxt = pkt_flush ? S_WB_REQ : S_FILL_REQ;
      end
      S_FILL_REQ: begin
        mreq_o  = 1'b1;
        maddr_o = base_q;
        if (mgnt_i) nxt = S_FILL_DATA;
      end
      S_FILL_DATA: begin
        away_o = way_q;
        if (mrvld_i) begin
          awe_o   = 1'b1;
          awdat_o = mrdat_i;
          aaddr_o = word_addr;
          cnt_inc = 1'b1;
          if (cnt_q == LAST) nxt = S_ACK;
        end
      end
      S_WB_REQ: begin
        mreq_o  = 1'b1;
        mwe_o   = 1'b1;
        maddr_o = base_q;
        if (mgnt_i) nxt = S_WB_RD;
      end
      S_WB_RD: begin
        are_o   = 1'b1;
        away_o  = way_q;
        aaddr_o = word_addr;
        nxt     = S_WB_DATA;
      end
      S_WB_DATA: begin
        mwvld_o = 1'b1;
        mwdat_o = first_q ? ardat_i : hold_q;
        if (mwrdy_i) begin
          cnt_inc = 1'b1;
          nxt     = (cnt_q == LAST) ? S_ACK : S_WB_RD;
        end
      end
      S_ACK: begin
        ack_o = 1'b1;
        nxt   = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_refill_engine.sv
// Bench for cache_refill_engine: memory and data-array behavioural models,
// a per-request reference of the expected bursts, and scenario tasks.
module tb_cache_refill_engine;

  localparam int LW         = 4;
  localparam int LINE_BYTES = LW * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        qvld_i;
  logic        qrdy_o;
  logic [36:0] qdat_i;
  logic        ack_o;
  logic        mreq_o;
  logic        mgnt_i;
  logic        mwe_o;
  logic [31:0] maddr_o;
  logic        mrvld_i;
  logic [31:0] mrdat_i;
  logic        mwvld_o;
  logic        mwrdy_i;
  logic [31:0] mwdat_o;
  logic        are_o;
  logic        awe_o;
  logic [3:0]  away_o;
  logic [31:0] aaddr_o;
  logic [31:0] awdat_o;
  logic [31:0] ardat_i;

  cache_refill_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WAYS(4), .LINE_WORDS(LW)) dut (
    .clk(clk), .reset(reset), .qvld_i(qvld_i), .qrdy_o(qrdy_o), .qdat_i(qdat_i),
    .ack_o(ack_o), .mreq_o(mreq_o), .mgnt_i(mgnt_i), .mwe_o(mwe_o), .maddr_o(maddr_o),
    .mrvld_i(mrvld_i), .mrdat_i(mrdat_i), .mwvld_o(mwvld_o), .mwrdy_i(mwrdy_i),
    .mwdat_o(mwdat_o), .are_o(are_o), .awe_o(awe_o), .away_o(away_o), .aaddr_o(aaddr_o),
    .awdat_o(awdat_o), .ardat_i(ardat_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int gnt_pct = 100, rvld_pct = 100, wrdy_pct = 100;
  int gnt_stall = 0, wrdy_stall = 0, wrdy_stall_word = 0;
  int stall_cnt = 0, ack_cnt = 0, beat_cnt = 0, ack_cyc = 0, beat_cyc = 0;
  bit busy = 0, prev_req = 0, prev_w = 0, ard_pend = 0;
  logic        prev_we;
  logic [31:0] prev_addr, prev_wdat, ard_next;

  logic [31:0] rd_q[$];
  logic [31:0] mw_obs[$];
  logic [67:0] aw_obs[$];
  logic [32:0] req_log[$];
  logic [31:0] amem[logic [35:0]];
  logic [31:0] mmem[logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mmem.exists(a)) return mmem[a];
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  function automatic logic [31:0] arr_rd(input logic [3:0] w, input logic [31:0] a);
    if (amem.exists({w, a})) return amem[{w, a}];
    return a ^ {w, 28'h0A5_5AA5};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory/array models drive at the falling edge, then observe one step later.
  always @(negedge clk) begin
    if (reset) begin
      mgnt_i  = 1'b0;
      mrvld_i = 1'b0;
      mwrdy_i = 1'b0;
      mrdat_i = '0;
      ardat_i = '0;
    end else begin
      mgnt_i = (gnt_stall == 0) && ($urandom_range(99) < gnt_pct);
      if (rd_q.size() > 0 && $urandom_range(99) < rvld_pct) begin
        mrvld_i = 1'b1;
        mrdat_i = rd_q.pop_front();
      end else begin
        mrvld_i = 1'b0;
        mrdat_i = $urandom;
      end
      mwrdy_i = (wrdy_stall > 0 && mw_obs.size() == wrdy_stall_word) ? 1'b0
                : ($urandom_range(99) < wrdy_pct);
      ardat_i  = ard_pend ? ard_next : $urandom;
      ard_pend = 0;
    end
    #1;
    if (reset) begin
      busy = 0; prev_req = 0; prev_w = 0; ard_pend = 0;
      rd_q.delete();
    end else begin
      total++;
      if (qrdy_o !== !busy) begin
        bad++; $display("FAIL qrdy: got %0b want %0b cyc %0d", qrdy_o, !busy, cyc);
      end
      total++;
      if ($countones(away_o) > 1) begin
        bad++; $display("FAIL away_onehot: got %b want at most one bit", away_o);
      end
      if (prev_req) begin
        total++;
        if (mreq_o !== 1'b1 || maddr_o !== prev_addr || mwe_o !== prev_we) begin
          bad++; $display("FAIL req_hold: got %0b/%h/%0b want 1/%h/%0b",
                          mreq_o, maddr_o, mwe_o, prev_addr, prev_we);
        end
      end
      if (prev_w) begin
        total++;
        if (mwvld_o !== 1'b1 || mwdat_o !== prev_wdat) begin
          bad++; $display("FAIL wdat_hold: got %0b/%h want 1/%h", mwvld_o, mwdat_o, prev_wdat);
        end
      end
      prev_req  = mreq_o && !mgnt_i;
      prev_addr = maddr_o;
      prev_we   = mwe_o;
      prev_w    = mwvld_o && !mwrdy_i;
      prev_wdat = mwdat_o;
      if (mreq_o && !mgnt_i) begin
        stall_cnt++;
        if (gnt_stall > 0) gnt_stall--;
      end
      if (mreq_o && mgnt_i) begin
        req_log.push_back({mwe_o, maddr_o});
        if (!mwe_o) for (int i = 0; i < LW; i++) rd_q.push_back(mem_rd(maddr_o + 32'(4 * i)));
      end
      if (awe_o) begin
        aw_obs.push_back({away_o, aaddr_o, awdat_o});
        amem[{away_o, aaddr_o}] = awdat_o;
      end
      if (are_o) begin
        ard_next = arr_rd(away_o, aaddr_o);
        ard_pend = 1;
      end
      if (mwvld_o && !mwrdy_i && wrdy_stall > 0 && mw_obs.size() == wrdy_stall_word) wrdy_stall--;
      if (mwvld_o && mwrdy_i) mw_obs.push_back(mwdat_o);
      if (ack_o) begin ack_cnt++; ack_cyc = cyc; busy = 0; end
      if (qvld_i && qrdy_o) begin beat_cnt++; beat_cyc = cyc; busy = 1; end
    end
  end

  // Offer one packet, wait for completion and compare everything against
  // what the request should have produced.
  task automatic run_packet(input logic fl, input logic [3:0] w, input logic [31:0] a,
                            input bit zero_wait);
    logic [31:0] base;
    logic [3:0]  woh;
    int          b0;
    bit          got;
    base = a & ~32'(LINE_BYTES - 1);
    woh  = (w == 4'd0) ? 4'b0001 : (w & (~w + 4'd1));
    aw_obs.delete(); mw_obs.delete(); req_log.delete();
    ack_cnt = 0;
    b0      = beat_cnt;
    got     = 0;
    @(negedge clk);
    qvld_i = 1'b1;
    qdat_i = {fl, w, a};
    for (int i = 0; i < 100; i++) begin
      #2;
      if (beat_cnt != b0) begin got = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    qvld_i = 1'b0;
    qdat_i = 37'({$urandom, $urandom});
    total++;
    if (!got) begin bad++; $display("FAIL beat: got none want accept of %h", a); end
    for (int i = 0; i < 400 && ack_cnt == 0; i++) begin @(negedge clk); #2; end
    repeat (3) @(negedge clk);
    #2;
    total++;
    if (ack_cnt != 1) begin bad++; $display("FAIL ack_count: got %0d want 1", ack_cnt); end
    if (zero_wait) begin
      total++;
      if (ack_cyc - beat_cyc != (fl ? 2 * LW + 2 : LW + 2)) begin
        bad++; $display("FAIL latency: got %0d want %0d", ack_cyc - beat_cyc, fl ? 2 * LW + 2 : LW + 2);
      end
    end
    total++;
    if (req_log.size() != 1 || req_log[0] !== {fl, base}) begin
      bad++; $display("FAIL mem_req: got n=%0d %h want %h", req_log.size(),
                      (req_log.size() > 0) ? req_log[0] : 33'h0, {fl, base});
    end
    if (!fl) begin
      total++;
      if (aw_obs.size() != LW || mw_obs.size() != 0) begin
        bad++; $display("FAIL fill_count: got %0d/%0d want %0d/0", aw_obs.size(), mw_obs.size(), LW);
      end
      for (int i = 0; i < LW && i < aw_obs.size(); i++) begin
        total++;
        if (aw_obs[i] !== {woh, base + 32'(4 * i), mem_rd(base + 32'(4 * i))}) begin
          bad++; $display("FAIL fill_word%0d: got %h want %h", i, aw_obs[i],
                          {woh, base + 32'(4 * i), mem_rd(base + 32'(4 * i))});
        end
      end
    end else begin
      total++;
      if (mw_obs.size() != LW || aw_obs.size() != 0) begin
        bad++; $display("FAIL wb_count: got %0d/%0d want %0d/0", mw_obs.size(), aw_obs.size(), LW);
      end
      for (int i = 0; i < LW && i < mw_obs.size(); i++) begin
        total++;
        if (mw_obs[i] !== arr_rd(woh, base + 32'(4 * i))) begin
          bad++; $display("FAIL wb_word%0d: got %h want %h", i, mw_obs[i], arr_rd(woh, base + 32'(4 * i)));
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #23;
    total++;
    if ({mreq_o, mwe_o, mwvld_o, are_o, awe_o, ack_o, qrdy_o} !== 7'b0000001) begin
      bad++; $display("FAIL reset_ctl: got %b want 0000001",
                      {mreq_o, mwe_o, mwvld_o, are_o, awe_o, ack_o, qrdy_o});
    end
    total++;
    if ({maddr_o, aaddr_o, away_o, awdat_o, mwdat_o} !== '0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {maddr_o, aaddr_o, away_o, awdat_o, mwdat_o});
    end
    @(negedge clk);
    #3 reset = 1'b0;
  endtask

  task automatic test_fill;
    for (int i = 0; i < LW; i++) mmem[32'h1230 + 32'(4 * i)] = 32'hA0 + 32'(i);
    run_packet(1'b0, 4'b0100, 32'h0000_1234, 1);
  endtask

  task automatic test_writeback;
    for (int i = 0; i < LW; i++) amem[{4'b0001, 32'h2000 + 32'(4 * i)}] = 32'hB0 + 32'(i);
    wrdy_stall_word = 1;
    wrdy_stall      = 3;
    run_packet(1'b1, 4'b0001, 32'h0000_2000, 0);
    total++;
    if (wrdy_stall != 0) begin bad++; $display("FAIL wb_stall: got %0d left want 0", wrdy_stall); end
    run_packet(1'b1, 4'b0001, 32'h0000_2000, 1);
  endtask

  task automatic test_way_norm;
    run_packet(1'b0, 4'b0000, 32'h0000_5008, 1);
    total++;
    if (aw_obs.size() == 0 || aw_obs[0][67:64] !== 4'b0001) begin
      bad++; $display("FAIL way_zero: got %b want 0001", (aw_obs.size() > 0) ? aw_obs[0][67:64] : 4'hx);
    end
    run_packet(1'b1, 4'b0110, 32'h0000_600C, 1);
    run_packet(1'b0, 4'b0110, 32'h0000_700C, 1);
    total++;
    if (aw_obs.size() == 0 || aw_obs[0][67:64] !== 4'b0010) begin
      bad++; $display("FAIL way_multi: got %b want 0010", (aw_obs.size() > 0) ? aw_obs[0][67:64] : 4'hx);
    end
  endtask

  task automatic test_backpressure;
    stall_cnt = 0;
    gnt_stall = 5;
    run_packet(1'b0, 4'b1000, 32'h0000_8010, 0);
    total++;
    if (stall_cnt != 5) begin bad++; $display("FAIL gnt_stall: got %0d want 5", stall_cnt); end
    stall_cnt = 0;
    gnt_stall = 5;
    run_packet(1'b1, 4'b1000, 32'h0000_8010, 0);
    total++;
    if (stall_cnt != 5) begin bad++; $display("FAIL gnt_stall_wb: got %0d want 5", stall_cnt); end
  endtask

  task automatic test_back_to_back;
    int b0;
    aw_obs.delete(); mw_obs.delete(); req_log.delete();
    ack_cnt = 0;
    b0      = beat_cnt;
    @(negedge clk);
    qvld_i = 1'b1;
    qdat_i = {1'b0, 4'b0100, 32'h0000_3004};
    for (int i = 0; i < 50 && beat_cnt == b0; i++) begin #2; if (beat_cnt == b0) @(negedge clk); end
    @(negedge clk);
    qdat_i = {1'b1, 4'b0100, 32'h0000_3008};
    for (int i = 0; i < 200 && beat_cnt < b0 + 2; i++) begin @(negedge clk); #2; end
    total++;
    if (beat_cnt != b0 + 2 || ack_cnt != 1 || beat_cyc != ack_cyc + 1) begin
      bad++; $display("FAIL b2b_accept: got beats=%0d acks=%0d gap=%0d want 2/1/1",
                      beat_cnt - b0, ack_cnt, beat_cyc - ack_cyc);
    end
    @(negedge clk);
    qvld_i = 1'b0;
    for (int i = 0; i < 200 && ack_cnt < 2; i++) begin @(negedge clk); #2; end
    repeat (2) @(negedge clk);
    total++;
    if (ack_cnt != 2 || mw_obs.size() != LW) begin
      bad++; $display("FAIL b2b_done: got acks=%0d words=%0d want 2/%0d", ack_cnt, mw_obs.size(), LW);
    end
    for (int i = 0; i < LW && i < mw_obs.size(); i++) begin
      total++;
      if (mw_obs[i] !== mem_rd(32'h3000 + 32'(4 * i))) begin
        bad++; $display("FAIL b2b_word%0d: got %h want %h", i, mw_obs[i], mem_rd(32'h3000 + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_reset_mid_fill;
    aw_obs.delete();
    ack_cnt = 0;
    @(negedge clk);
    qvld_i = 1'b1;
    qdat_i = {1'b0, 4'b0010, 32'h0000_4444};
    @(negedge clk);
    qvld_i = 1'b0;
    #2;
    for (int i = 0; i < 50 && aw_obs.size() < 2; i++) begin @(negedge clk); #2; end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({mreq_o, mwe_o, mwvld_o, are_o, awe_o, ack_o, qrdy_o} !== 7'b0000001) begin
      bad++; $display("FAIL midrst_ctl: got %b want 0000001",
                      {mreq_o, mwe_o, mwvld_o, are_o, awe_o, ack_o, qrdy_o});
    end
    total++;
    if ({maddr_o, aaddr_o, away_o, awdat_o, mwdat_o} !== '0) begin
      bad++; $display("FAIL midrst_data: got %h want 0", {maddr_o, aaddr_o, away_o, awdat_o, mwdat_o});
    end
    @(negedge clk);
    #3 reset = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    total++;
    if (ack_cnt != 0 || aw_obs.size() != 2) begin
      bad++; $display("FAIL midrst_abandon: got acks=%0d writes=%0d want 0/2", ack_cnt, aw_obs.size());
    end
    run_packet(1'b0, 4'b0010, 32'h0000_4444, 1);
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int n = 0; n < 24; n++) begin
      gnt_pct  = $urandom_range(100, 40);
      rvld_pct = $urandom_range(100, 40);
      wrdy_pct = $urandom_range(100, 40);
      a = (n == 5) ? 32'hFFFF_FFFC : $urandom;
      run_packet(1'($urandom_range(1)), 4'($urandom_range(15)), a, 0);
    end
    gnt_pct = 100; rvld_pct = 100; wrdy_pct = 100;
  endtask

  initial begin
    reset   = 1'b1;
    qvld_i  = 1'b0;
    qdat_i  = '0;
    mgnt_i  = 1'b0;
    mrvld_i = 1'b0;
    mrdat_i = '0;
    mwrdy_i = 1'b0;
    ardat_i = '0;
    test_reset();
    test_fill();
    test_writeback();
    test_way_norm();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
